// File: rtl/spram_writer.sv
// Fills a contiguous SPRAM region from a valid/ready byte stream, then optionally
// reads the region back and compares its modular checksum against what was written.
module spram_writer #(
  parameter int unsigned addrbits = 9,
  parameter int unsigned databits = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [addrbits-1:0] base_addr,
  input  logic [addrbits:0]   length,
  input  logic                verify,
  input  logic [databits-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [addrbits-1:0] mem_address,
  output logic [databits-1:0] mem_data,
  output logic                mem_wren,
  input  logic [databits-1:0] mem_q,
  output logic                busy,
  output logic                done,
  output logic                verify_fail,
  output logic [databits-1:0] checksum
);

  localparam logic [addrbits:0]   CntOne  = 1;
  localparam logic [addrbits-1:0] AddrOne = 1;

  typedef enum logic [2:0] {StIdle, StWrite, StGap, StVerify, StDone} state_e;

  state_e state_q, state_d;

  logic [addrbits-1:0] base_q, base_d;
  logic [addrbits:0]   len_q, len_d;
  logic                verify_en_q, verify_en_d;
  logic [addrbits-1:0] wr_addr_q, wr_addr_d;
  logic [addrbits:0]   wr_count_q, wr_count_d;
  logic [databits-1:0] sum_q, sum_d;
  logic [addrbits-1:0] rd_addr_q, rd_addr_d;
  logic [addrbits:0]   rd_count_q, rd_count_d;
  logic [databits-1:0] rsum_q, rsum_d;
  // [0]: address presented this cycle, [1]: its read data is on mem_q this cycle
  logic [1:0]          rd_pipe_q, rd_pipe_d;

  logic                in_ready_q, in_ready_d;
  logic [addrbits-1:0] mem_address_q, mem_address_d;
  logic [databits-1:0] mem_data_q, mem_data_d;
  logic                mem_wren_q, mem_wren_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                verify_fail_q, verify_fail_d;
  logic [databits-1:0] checksum_q, checksum_d;

  logic start_ok, zero_len, accept, last_beat, issue, verify_last;

  assign start_ok    = (state_q == StIdle) && start;
  assign zero_len    = (length == '0);
  assign accept      = (state_q == StWrite) && in_valid && in_ready_q;
  assign last_beat   = accept && ((wr_count_q + CntOne) == len_q);
  assign issue       = (state_q == StVerify) && (rd_count_q != len_q);
  assign verify_last = (state_q == StVerify) && !issue && rd_pipe_q[1] && !rd_pipe_q[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start && !zero_len) state_d = StWrite;
      StWrite:  if (last_beat) state_d = StGap;
      StGap:    state_d = verify_en_q ? StVerify : StDone;
      StVerify: if (verify_last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    base_d        = base_q;
    len_d         = len_q;
    verify_en_d   = verify_en_q;
    wr_addr_d     = wr_addr_q;
    wr_count_d    = wr_count_q;
    sum_d         = sum_q;
    rd_addr_d     = rd_addr_q;
    rd_count_d    = rd_count_q;
    rsum_d        = rsum_q;
    rd_pipe_d     = {rd_pipe_q[0], issue};
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    verify_fail_d = verify_fail_q;
    checksum_d    = checksum_q;

    if (start_ok && !zero_len) begin
      base_d        = base_addr;
      len_d         = length;
      verify_en_d   = verify;
      wr_addr_d     = base_addr;
      wr_count_d    = '0;
      sum_d         = '0;
      verify_fail_d = 1'b0;
    end
    if (start_ok && zero_len) begin
      checksum_d    = '0;
      verify_fail_d = 1'b0;
    end

    if (accept) begin
      mem_address_d = wr_addr_q;
      mem_data_d    = in_data;
      wr_addr_d     = wr_addr_q + AddrOne;
      wr_count_d    = wr_count_q + CntOne;
      sum_d         = sum_q + in_data;
    end

    if (state_q == StGap) begin
      rd_addr_d  = base_q;
      rd_count_d = '0;
      rsum_d     = '0;
    end else if (rd_pipe_q[1]) begin
      rsum_d = rsum_q + mem_q;
    end

    if (issue) begin
      mem_address_d = rd_addr_q;
      rd_addr_d     = rd_addr_q + AddrOne;
      rd_count_d    = rd_count_q + CntOne;
    end

    if (state_d == StDone) begin
      checksum_d    = sum_q;
      verify_fail_d = verify_en_q && (rsum_d != sum_q);
    end

    mem_wren_d = accept;
    in_ready_d = (state_d == StWrite);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone) || (start_ok && zero_len);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q        <= '0;
      len_q         <= '0;
      verify_en_q   <= 1'b0;
      wr_addr_q     <= '0;
      wr_count_q    <= '0;
      sum_q         <= '0;
      rd_addr_q     <= '0;
      rd_count_q    <= '0;
      rsum_q        <= '0;
      rd_pipe_q     <= '0;
      in_ready_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      verify_fail_q <= 1'b0;
      checksum_q    <= '0;
    end else begin
      base_q        <= base_d;
      len_q         <= len_d;
      verify_en_q   <= verify_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_count_q    <= wr_count_d;
      sum_q         <= sum_d;
      rd_addr_q     <= rd_addr_d;
      rd_count_q    <= rd_count_d;
      rsum_q        <= rsum_d;
      rd_pipe_q     <= rd_pipe_d;
      in_ready_q    <= in_ready_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      verify_fail_q <= verify_fail_d;
      checksum_q    <= checksum_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign verify_fail = verify_fail_q;
  assign checksum    = checksum_q;

endmodule

// File: tb/tb_spram_writer.sv
// Bench for spram_writer: SPRAM behavioural model plus a load-level reference model
// (expected address list, byte sum, readback sum) checked against randomized loads.
module tb_spram_writer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, start, verify, in_valid, in_ready, mem_wren, busy, done, verify_fail;
  logic [8:0] base_addr, mem_address;
  logic [9:0] length;
  logic [7:0] in_data, mem_data, mem_q, checksum;

  spram_writer #(.addrbits(9), .databits(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .verify      (verify),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .busy        (busy),
    .done        (done),
    .verify_fail (verify_fail),
    .checksum    (checksum)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [7:0] mem [512];
  logic [7:0] stream [512];
  bit         corrupt_en = 1'b0;
  logic [8:0] corrupt_addr = '0;

  logic [8:0] mon_addr [$];
  logic [7:0] mon_data [$];
  int         mon_cyc [$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         start_cyc = 0;
  bit         busy_at_done = 1'b0;
  bit         activity = 1'b0;

  // SPRAM: registered read, q valid one clock after the address is sampled
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= (corrupt_en && mem_address == corrupt_addr) ? 8'h31
                                                                                    : mem_data;
    mem_q <= mem[mem_address];
    cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (mem_wren) begin
      mon_addr.push_back(mem_address);
      mon_data.push_back(mem_data);
      mon_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (busy || in_ready || mem_wren) activity = 1'b1;
  end

  // mode 0: valid every cycle, 1: alternate valid/idle, 2: random valid
  task automatic do_load(input logic [8:0] b, input logic [9:0] n, input bit v, input int mode,
                         output bit timed_out, output bit vf_after);
    int idx, cycles, dc0, limit;
    bit toggle;
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
    dc0 = done_cnt;
    limit = 8 * int'(n) + 50;
    @(negedge clock);
    start = 1'b1;
    base_addr = b;
    length = n;
    verify = v;
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
    vf_after = verify_fail;
    idx = 0;
    cycles = 0;
    toggle = 1'b1;
    while (done_cnt == dc0 && cycles < limit) begin
      if (idx < int'(n)) begin
        in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? toggle : 1'($urandom_range(1));
        in_data = stream[idx];
      end else begin
        in_valid = 1'b0;
      end
      toggle = !toggle;
      if (in_valid && in_ready) idx++;
      @(negedge clock);
      cycles++;
    end
    in_valid = 1'b0;
    timed_out = (done_cnt == dc0);
  endtask

  function automatic logic [7:0] ref_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(stream[i]);
    return 8'(s % 256);
  endfunction

  function automatic int ref_bad_writes(input logic [8:0] b, input int n);
    int bad = 0;
    if (mon_addr.size() != n) bad++;
    for (int i = 0; i < n && i < mon_addr.size(); i++) begin
      if (mon_addr[i] !== 9'((int'(b) + i) % 512) || mon_data[i] !== stream[i]) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; verify = 1'b0; in_valid = 1'b0;
    base_addr = '0; length = '0; in_data = '0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({in_ready, mem_wren, busy, done, verify_fail} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000", {in_ready, mem_wren, busy, done, verify_fail});
    else n_pass++;
    n_checks++;
    if ({mem_address, mem_data, checksum} !== 25'h0)
      $display("FAIL reset_data got %h/%h/%h want 0/0/0", mem_address, mem_data, checksum);
    else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({in_ready, busy, done} !== 3'b0)
      $display("FAIL reset_idle got %b want 000", {in_ready, busy, done});
    else n_pass++;
  endtask

  task automatic test_basic_load();
    bit to, vf;
    int bad;
    stream[0] = 8'hA5; stream[1] = 8'h01; stream[2] = 8'h02; stream[3] = 8'h03;
    do_load(9'd0, 10'd4, 1'b0, 0, to, vf);
    bad = ref_bad_writes(9'd0, 4);
    n_checks++;
    if (to || bad != 0) $display("FAIL basic_writes timeout=%0d bad=%0d want 0/0", to, bad);
    else n_pass++;
    n_checks++;
    if (mon_cyc.size() != 4 || mon_cyc[3] - mon_cyc[0] != 3)
      $display("FAIL basic_consecutive got %0d writes want 4 back-to-back", mon_cyc.size());
    else n_pass++;
    n_checks++;
    if (mon_cyc.size() != 4 || done_cyc != mon_cyc[3] + 1 || busy_at_done !== 1'b1)
      $display("FAIL basic_done_timing got cyc %0d busy %b want last write + 1, busy 1",
               done_cyc, busy_at_done);
    else n_pass++;
    n_checks++;
    if (checksum !== 8'hAB || verify_fail !== 1'b0)
      $display("FAIL basic_checksum got %h/%b want AB/0", checksum, verify_fail);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL basic_after got %b want 00", {busy, done});
    else n_pass++;
  endtask

  task automatic test_wrap_verify();
    bit to, vf;
    int bad;
    stream[0] = 8'h10; stream[1] = 8'h20; stream[2] = 8'h30; stream[3] = 8'h40;
    do_load(9'd510, 10'd4, 1'b1, 1, to, vf);
    bad = ref_bad_writes(9'd510, 4);
    n_checks++;
    if (to || bad != 0) $display("FAIL wrap_writes timeout=%0d bad=%0d want 0/0", to, bad);
    else n_pass++;
    n_checks++;
    if (mon_cyc.size() != 4 || mon_cyc[3] - mon_cyc[0] != 6)
      $display("FAIL wrap_valid_gaps got %0d writes want 4 on alternate cycles", mon_cyc.size());
    else n_pass++;
    n_checks++;
    if (checksum !== ref_sum(4) || verify_fail !== 1'b0)
      $display("FAIL wrap_checksum got %h/%b want %h/0", checksum, verify_fail, ref_sum(4));
    else n_pass++;
  endtask

  task automatic test_verify_corrupt();
    bit to, vf;
    stream[0] = 8'h10; stream[1] = 8'h20; stream[2] = 8'h30; stream[3] = 8'h40;
    corrupt_en = 1'b1;
    corrupt_addr = 9'd0;
    do_load(9'd510, 10'd4, 1'b1, 1, to, vf);
    corrupt_en = 1'b0;
    n_checks++;
    if (to || checksum !== 8'hA0 || verify_fail !== 1'b1)
      $display("FAIL corrupt_detect got %h/%b want A0/1", checksum, verify_fail);
    else n_pass++;
    stream[0] = 8'h07; stream[1] = 8'hF0;
    do_load(9'd20, 10'd2, 1'b1, 0, to, vf);
    n_checks++;
    if (vf !== 1'b0) $display("FAIL corrupt_clear_on_start got %b want 0", vf);
    else n_pass++;
    n_checks++;
    if (to || checksum !== 8'hF7 || verify_fail !== 1'b0)
      $display("FAIL corrupt_clean_reload got %h/%b want F7/0", checksum, verify_fail);
    else n_pass++;
  endtask

  task automatic test_zero_length();
    bit to, vf;
    int dc0;
    @(negedge clock);
    activity = 1'b0;
    dc0 = done_cnt;
    do_load(9'd33, 10'd0, 1'b1, 0, to, vf);
    n_checks++;
    if (to || done_cyc != start_cyc + 1)
      $display("FAIL zero_done_timing got cyc %0d want %0d", done_cyc, start_cyc + 1);
    else n_pass++;
    n_checks++;
    if (checksum !== 8'h00 || verify_fail !== 1'b0)
      $display("FAIL zero_outputs got %h/%b want 00/0", checksum, verify_fail);
    else n_pass++;
    repeat (4) @(negedge clock);
    n_checks++;
    if (activity !== 1'b0 || done_cnt != dc0 + 1)
      $display("FAIL zero_quiet got activity %b pulses %0d want 0/1", activity, done_cnt - dc0);
    else n_pass++;
  endtask

  task automatic test_full_length();
    bit to, vf;
    int bad;
    logic [8:0] b = 9'd37;
    for (int i = 0; i < 512; i++) stream[i] = 8'((int'(b) + i) % 512);
    do_load(b, 10'd512, 1'b1, 0, to, vf);
    bad = ref_bad_writes(b, 512);
    n_checks++;
    if (to || bad != 0) $display("FAIL full_writes timeout=%0d bad=%0d want 0/0", to, bad);
    else n_pass++;
    n_checks++;
    if (checksum !== ref_sum(512) || verify_fail !== 1'b0)
      $display("FAIL full_checksum got %h/%b want %h/0", checksum, verify_fail, ref_sum(512));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to, vf;
    int dc0;
    dc0 = done_cnt;
    @(negedge clock);
    start = 1'b1; base_addr = 9'd100; length = 10'd4; verify = 1'b0;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    @(negedge clock);
    in_data = 8'h22;
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({mem_wren, in_ready, busy, done} !== 4'b0)
      $display("FAIL midreset_ctrl got %b want 0000", {mem_wren, in_ready, busy, done});
    else n_pass++;
    reset = 1'b0;
    repeat (6) @(negedge clock);
    n_checks++;
    if (done_cnt != dc0 || mem[100] !== 8'h11 || mem[101] !== 8'h22)
      $display("FAIL midreset_state got pulses %0d mem %h %h want 0 11 22",
               done_cnt - dc0, mem[100], mem[101]);
    else n_pass++;
    stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03; stream[3] = 8'h04;
    do_load(9'd200, 10'd4, 1'b1, 2, to, vf);
    n_checks++;
    if (to || ref_bad_writes(9'd200, 4) != 0 || checksum !== 8'h0A || verify_fail !== 1'b0)
      $display("FAIL midreset_reload got %h/%b want 0A/0", checksum, verify_fail);
    else n_pass++;
  endtask

  task automatic test_random_loads();
    bit to, vf, v, exp_fail;
    int n, ci, rs, mode;
    logic [8:0] b;
    for (int it = 0; it < 8; it++) begin
      b = 9'($urandom_range(511));
      n = int'($urandom_range(64, 1));
      v = 1'($urandom_range(1));
      mode = int'($urandom_range(2));
      for (int i = 0; i < n; i++) stream[i] = 8'($urandom_range(255));
      corrupt_en = v && ($urandom_range(1) == 1);
      ci = int'($urandom_range(n - 1));
      corrupt_addr = 9'((int'(b) + ci) % 512);
      rs = 0;
      for (int i = 0; i < n; i++) rs += (corrupt_en && i == ci) ? 'h31 : int'(stream[i]);
      exp_fail = v && (8'(rs % 256) != ref_sum(n));
      do_load(b, 10'(n), v, mode, to, vf);
      corrupt_en = 1'b0;
      n_checks++;
      if (to || ref_bad_writes(b, n) != 0 || checksum !== ref_sum(n) || verify_fail !== exp_fail)
        $display("FAIL random_load%0d base %0d len %0d got %h/%b want %h/%b",
                 it, b, n, checksum, verify_fail, ref_sum(n), exp_fail);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_wrap_verify();
    test_verify_corrupt();
    test_zero_length();
    test_full_length();
    test_reset_mid();
    test_random_loads();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spram_writer.md
Name: spram_writer

Overview:
- Write-side companion to the read-only spram instance; fills a contiguous SPRAM region from a valid/ready byte stream.
- Optionally re-reads the region and checks a modular checksum of what was written.
- Sits between a loader source (UART/flash streamer) and the spram address/data/wren/q pins; owns the memory port while busy.

Parameters:
addrbits, 9, SPRAM address width; matches the spram instance.
databits, 8, SPRAM word width; matches the spram instance.

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a load; sampled only in IDLE
base_addr  in  addrbits  first word address; captured on accepted start
length  in  addrbits+1  number of words, 0..2^addrbits; captured on accepted start
verify  in  1  enable readback checksum pass; captured on accepted start
in_data  in  databits  stream word
in_valid  in  1  stream word valid
in_ready  out  1  block accepts a word this cycle
mem_address  out  addrbits  to spram address
mem_data  out  databits  to spram data
mem_wren  out  1  to spram wren; 1 = write, 0 = read
mem_q  in  databits  from spram q
busy  out  1  high from the cycle after an accepted start until DONE exits
done  out  1  one-cycle completion pulse
verify_fail  out  1  checksum mismatch on last verified load; held until next accepted start
checksum  out  databits  sum mod 2^databits of all words written in last load

Behaviour:
- All outputs registered.
- Reset values: in_ready=0, mem_address=0, mem_data=0, mem_wren=0, busy=0, done=0, verify_fail=0, checksum=0; state=IDLE.
- States: IDLE, WRITE, GAP, VERIFY, DONE.
- IDLE:
  - start=1 with length=0: done=1 for one cycle, checksum=0, verify_fail=0; remain IDLE, busy stays 0.
  - start=1 with length>0: capture base_addr/length/verify; clear sum, counters and verify_fail; next state WRITE.
- start outside IDLE is ignored.
- WRITE:
  - in_ready=1 in every WRITE cycle except the cycle after the final beat is accepted.
  - A beat is accepted when in_valid&in_ready.
  - On accept: mem_address<=wr_addr, mem_data<=in_data, mem_wren<=1, all visible next cycle.
  - On accept: wr_addr<=wr_addr+1, wrapping mod 2^addrbits (base 510, len 4 writes 510, 511, 0, 1).
  - On accept: sum<=sum+in_data mod 2^databits.
  - mem_wren is 1 exactly one cycle per accepted beat and 0 otherwise.
  - in_valid=0 stalls indefinitely with no timeout.
- After the length-th accept: in_ready<=0 and next state GAP, so the final write commits.
- GAP (one cycle): mem_wren=0.
  - If verify: next state VERIFY; rd_addr=base, rd_count=0, rsum=0.
  - Else: next state DONE.
- VERIFY:
  - Present rd_addr on mem_address with mem_wren=0, one new address per cycle, for length cycles; rd_addr wraps like wr_addr.
  - spram returns q one clock after it samples the address. A 2-stage valid pipeline aligns sampling: mem_q for the address registered at edge k is added to rsum at edge k+2.
  - Leave VERIFY when the last valid pipeline stage retires.
- DONE (one cycle):
  - done=1, checksum<=sum.
  - If verify was enabled: verify_fail<=(rsum!=sum); otherwise verify_fail stays 0.
  - Next state IDLE; busy<=0 on the same edge done drops.
- length=2^addrbits: every word written once; the address returns to base after the last write.
- Reset mid-operation:
  - Next edge: IDLE, mem_wren=0, in_ready=0, done=0.
  - Words already written stay in memory; no partial done.
- mem_data is don't-care when mem_wren=0 but holds its last value.

Test Plan:
- Reset, then start base=0 len=4 verify=0, stream A5,01,02,03 back-to-back -> mem_wren high 4 consecutive cycles at addresses 0..3; done 1 cycle later with checksum=AB, verify_fail=0.
- base=510 len=4 verify=1 data 10,20,30,40, in_valid toggled 1/0 -> writes at 510, 511, 0, 1 only on valid cycles; VERIFY reads the same four addresses; checksum=A0, verify_fail=0.
- Same load, but the bench memory model corrupts address 0 to 31 before readback -> verify_fail=1 at done; cleared on the next accepted start.
- start with length=0 -> done pulses the next cycle; busy, in_ready and mem_wren never assert.
- length=512 with data = address[7:0] -> 512 writes, address returns to base; checksum=00, verify passes.
- Reset asserted after 2 of 4 beats -> next cycle mem_wren=0, in_ready=0, busy=0, no done; a following start runs normally.
